// File: rtl/scrypt_pkg.sv
// Shared types and constants for the scrypt SMIX job dispatcher.
package scrypt_pkg;

  localparam int BLOCK_W = 1024;

  typedef enum logic [1:0] {
    CORE_FREE  = 2'd0,
    CORE_START = 2'd1,
    CORE_BUSY  = 2'd2,
    CORE_HELD  = 2'd3
  } core_state_e;

endpackage

// File: rtl/scrypt_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, searching cyclically.
module scrypt_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any
);

  logic [PW-1:0] idx_s;

  // Cyclic scan starting at ptr; the modulo keeps non-power-of-two N correct.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx_s = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = PW'((int'(ptr) + k) % N);
      grant = (!any && req[idx_s]) ? idx_s : grant;
      any   = any | req[idx_s];
    end
  end

endmodule

// File: rtl/scrypt_smix_dispatch.sv
// Round-robin job scheduler for a bank of SMIX cores with per-core result holding
// registers and an out-of-order result return port.
module scrypt_smix_dispatch
  import scrypt_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int TAGW   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [BLOCK_W-1:0]          job_data,
  input  logic [TAGW-1:0]             job_tag,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [BLOCK_W-1:0]          res_hash,
  output logic [TAGW-1:0]             res_tag,
  output logic [NCORES-1:0]           core_enable,
  output logic [NCORES*BLOCK_W-1:0]   core_data,
  input  logic [NCORES*BLOCK_W-1:0]   core_hash,
  input  logic [NCORES-1:0]           core_done,
  output logic [3:0]                  cores_busy,
  output logic                        proto_err
);

  localparam int PW = $clog2(NCORES);

  core_state_e        state_r     [NCORES];
  core_state_e        state_nxt_s [NCORES];
  logic [BLOCK_W-1:0] data_r      [NCORES];
  logic [BLOCK_W-1:0] hold_r      [NCORES];
  logic [TAGW-1:0]    tag_r       [NCORES];

  logic [NCORES-1:0]  free_s, held_s, busy_s;
  logic [PW-1:0]      dptr_r, optr_r, out_sel_r;
  logic [PW-1:0]      disp_idx_s, pick_idx_s;
  logic               disp_any_s, pick_any_s;
  logic               accept_s, res_fire_s, proto_err_s;
  logic [NCORES-1:0]  enable_r;
  logic               res_valid_r, proto_err_r;
  logic [BLOCK_W-1:0] res_hash_r;
  logic [TAGW-1:0]    res_tag_r;
  logic [3:0]         busy_cnt_r, busy_cnt_s;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(NCORES - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  scrypt_rr_pick #(.N(NCORES), .PW(PW)) u_disp_pick (
    .req   (free_s),
    .ptr   (dptr_r),
    .grant (disp_idx_s),
    .any   (disp_any_s)
  );

  scrypt_rr_pick #(.N(NCORES), .PW(PW)) u_out_pick (
    .req   (held_s),
    .ptr   (optr_r),
    .grant (pick_idx_s),
    .any   (pick_any_s)
  );

  // Decode per-core state vectors and handshake qualifiers.
  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      free_s[i] = (state_r[i] == CORE_FREE);
      busy_s[i] = (state_r[i] == CORE_BUSY);
      held_s[i] = (state_r[i] == CORE_HELD);
    end
    accept_s    = job_valid && disp_any_s;
    res_fire_s  = res_valid_r && res_ready;
    proto_err_s = |(core_done & ~busy_s);
  end

  // Per-core next state and the resulting occupancy count.
  always_comb begin
    busy_cnt_s = 4'd0;
    for (int i = 0; i < NCORES; i++) begin
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        CORE_FREE: begin
          if (accept_s && (disp_idx_s == PW'(i))) state_nxt_s[i] = CORE_START;
          else                                     state_nxt_s[i] = CORE_FREE;
        end
        CORE_START: state_nxt_s[i] = CORE_BUSY;
        CORE_BUSY: begin
          if (core_done[i]) state_nxt_s[i] = CORE_HELD;
          else              state_nxt_s[i] = CORE_BUSY;
        end
        CORE_HELD: begin
          if (res_fire_s && (out_sel_r == PW'(i))) state_nxt_s[i] = CORE_FREE;
          else                                      state_nxt_s[i] = CORE_HELD;
        end
        default: state_nxt_s[i] = CORE_FREE;
      endcase
      busy_cnt_s = busy_cnt_s + {3'd0, (state_nxt_s[i] != CORE_FREE)};
    end
  end

  // State, per-core data/tag/hold registers, pointers and the result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCORES; i++) begin
        state_r[i] <= CORE_FREE;
        data_r[i]  <= '0;
        hold_r[i]  <= '0;
        tag_r[i]   <= '0;
      end
      dptr_r      <= '0;
      optr_r      <= '0;
      out_sel_r   <= '0;
      enable_r    <= '0;
      res_valid_r <= 1'b0;
      res_hash_r  <= '0;
      res_tag_r   <= '0;
      busy_cnt_r  <= 4'd0;
      proto_err_r <= 1'b0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        state_r[i]  <= state_nxt_s[i];
        enable_r[i] <= (state_nxt_s[i] == CORE_START);
        // data_r only changes on grant, so SMIX sees a stable block for the whole job
        if (accept_s && (disp_idx_s == PW'(i))) begin
          data_r[i] <= job_data;
          tag_r[i]  <= job_tag;
        end
        if (busy_s[i] && core_done[i]) begin
          hold_r[i] <= core_hash[i*BLOCK_W +: BLOCK_W];
        end
      end
      if (accept_s) begin
        dptr_r <= wrap_inc(disp_idx_s);
      end
      if (res_fire_s) begin
        res_valid_r <= 1'b0;
        optr_r      <= wrap_inc(out_sel_r);
      end else if (!res_valid_r && pick_any_s) begin
        res_valid_r <= 1'b1;
        out_sel_r   <= pick_idx_s;
        res_hash_r  <= hold_r[pick_idx_s];
        res_tag_r   <= tag_r[pick_idx_s];
      end
      busy_cnt_r  <= busy_cnt_s;
      proto_err_r <= proto_err_r | proto_err_s;
    end
  end

  for (genvar g = 0; g < NCORES; g++) begin : g_core_data
    assign core_data[g*BLOCK_W +: BLOCK_W] = data_r[g];
  end

  assign job_ready   = disp_any_s;
  assign core_enable = enable_r;
  assign res_valid   = res_valid_r;
  assign res_hash    = res_hash_r;
  assign res_tag     = res_tag_r;
  assign cores_busy  = busy_cnt_r;
  assign proto_err   = proto_err_r;

endmodule

// File: tb/tb_scrypt_smix_dispatch.sv
// Randomized and directed bench for scrypt_smix_dispatch against a job-occupancy
// reference model, with behavioural SMIX core stand-ins.
module tb_scrypt_smix_dispatch;

  localparam int N    = 4;
  localparam int TAGW = 8;
  localparam int BW   = 1024;

  logic            clk = 1'b0;
  logic            rst, job_valid, job_ready, res_valid, res_ready, proto_err;
  logic [BW-1:0]   job_data, res_hash;
  logic [TAGW-1:0] job_tag, res_tag;
  logic [N-1:0]    core_enable, core_done;
  logic [N*BW-1:0] core_data, core_hash;
  logic [3:0]      cores_busy;

  always #5 clk = ~clk;

  scrypt_smix_dispatch #(.NCORES(N), .TAGW(TAGW)) dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_data    (job_data),
    .job_tag     (job_tag),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_hash    (res_hash),
    .res_tag     (res_tag),
    .core_enable (core_enable),
    .core_data   (core_data),
    .core_hash   (core_hash),
    .core_done   (core_done),
    .cores_busy  (cores_busy),
    .proto_err   (proto_err)
  );

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [BW-1:0]   data;
  } job_t;

  int checks   = 0;
  int failures = 0;

  // reference model: 0 free, 1 start, 2 busy, 3 held
  int              m_phase [N];
  logic [BW-1:0]   m_data  [N];
  logic [TAGW-1:0] m_tag   [N];
  int              m_dptr, m_optr, m_sel;
  bit              m_pend, m_perr, m_rstchk;
  logic [N-1:0]    m_en;

  // SMIX core stand-ins
  int              c_cnt [N];
  logic [BW-1:0]   c_blk [N];
  int              lat_cfg [N];
  bit              lat_rand;

  job_t            jq[$];
  bit              dir_mode, job_taken;
  int              p_job, p_ready, inj_core;

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [BW-1:0] smix_f(input logic [BW-1:0] d);
    return {d[BW/2-1:0], d[BW-1:BW/2]} ^ {128{8'h5c}};
  endfunction

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int w = 0; w < BW/32; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < N; i++) if (m_phase[i] != 0) n++;
    return n;
  endfunction

  task automatic model_check();
    int occ;
    occ = model_occ();
    check_eq("job_ready",   BW'(job_ready),   BW'(occ < N));
    check_eq("cores_busy",  BW'(cores_busy),  BW'(occ));
    check_eq("core_enable", BW'(core_enable), BW'(m_en));
    check_eq("proto_err",   BW'(proto_err),   BW'(m_perr));
    check_eq("res_valid",   BW'(res_valid),   BW'(m_pend));
    if (m_pend) begin
      check_eq("res_tag",  BW'(res_tag), BW'(m_tag[m_sel]));
      check_eq("res_hash", res_hash,     smix_f(m_data[m_sel]));
    end
    for (int i = 0; i < N; i++) begin
      if (m_phase[i] != 0) check_eq("core_data", core_data[i*BW +: BW], m_data[i]);
    end
    if (m_rstchk) begin
      m_rstchk = 1'b0;
      for (int i = 0; i < N; i++) check_eq("rst_core_data", core_data[i*BW +: BW], '0);
      check_eq("rst_res_hash", res_hash, '0);
      check_eq("rst_res_tag",  BW'(res_tag), '0);
    end
  endtask

  task automatic cores_step();
    for (int i = 0; i < N; i++) begin
      core_done[i] = 1'b0;
      if (rst) begin
        c_cnt[i] = 0;
      end else begin
        if (c_cnt[i] > 0) begin
          c_cnt[i]--;
          if (c_cnt[i] == 0) begin
            core_done[i] = 1'b1;
            core_hash[i*BW +: BW] = smix_f(c_blk[i]);
          end
        end
        if (core_enable[i]) begin
          c_blk[i] = core_data[i*BW +: BW];
          c_cnt[i] = lat_rand ? int'($urandom_range(40, 1)) : lat_cfg[i];
        end
      end
    end
    if (!rst && inj_core >= 0 && m_phase[inj_core] == 0) begin
      core_done[inj_core] = 1'b1;
      inj_core = -1;
    end
  endtask

  task automatic gen_inputs();
    job_t j;
    if (job_taken) begin
      job_valid = 1'b0;
      job_taken = 1'b0;
    end
    if (!job_valid) begin
      if (dir_mode) begin
        if (jq.size() > 0) begin
          j = jq.pop_front();
          job_valid = 1'b1;
          job_tag   = j.tag;
          job_data  = j.data;
        end
      end else if ($urandom_range(99) < p_job) begin
        job_valid = 1'b1;
        job_tag   = TAGW'($urandom);
        job_data  = rand_block();
      end
    end
    res_ready = ($urandom_range(99) < p_ready);
  endtask

  // Predicts the effect of the coming clock edge from the stimulus now applied.
  task automatic model_step();
    int  old [N];
    int  g, h, idx, sel0;
    bit  pend0, accept;
    if (rst) begin
      for (int i = 0; i < N; i++) m_phase[i] = 0;
      m_dptr = 0; m_optr = 0; m_sel = 0;
      m_pend = 1'b0; m_perr = 1'b0; m_en = '0; m_rstchk = 1'b1;
      return;
    end
    for (int i = 0; i < N; i++) old[i] = m_phase[i];
    pend0 = m_pend;
    sel0  = m_sel;
    for (int i = 0; i < N; i++) if (core_done[i] && old[i] != 2) m_perr = 1'b1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_dptr + k) % N;
      if (g < 0 && old[idx] == 0) g = idx;
    end
    accept = job_valid && (g >= 0);
    m_en = '0;
    for (int i = 0; i < N; i++) begin
      case (old[i])
        0: if (accept && g == i) begin
             m_phase[i] = 1; m_data[i] = job_data; m_tag[i] = job_tag; m_en[i] = 1'b1;
           end
        1: m_phase[i] = 2;
        2: if (core_done[i]) m_phase[i] = 3;
        3: if (pend0 && res_ready && sel0 == i) m_phase[i] = 0;
        default: m_phase[i] = 0;
      endcase
    end
    if (accept) begin
      m_dptr    = (g + 1) % N;
      job_taken = 1'b1;
    end
    if (pend0) begin
      if (res_ready) begin
        m_pend = 1'b0;
        m_optr = (sel0 + 1) % N;
      end
    end else begin
      h = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_optr + k) % N;
        if (h < 0 && old[idx] == 3) h = idx;
      end
      if (h >= 0) begin
        m_sel  = h;
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit r);
    @(negedge clk);
    model_check();
    rst = r;
    cores_step();
    gen_inputs();
    model_step();
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while ((model_occ() != 0 || job_valid || jq.size() > 0) && c < maxc) begin
      cycle(1'b0);
      c++;
    end
    check_eq("drain_idle", BW'(model_occ() + int'(job_valid) + jq.size()), '0);
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat_cfg[0] = l0; lat_cfg[1] = l1; lat_cfg[2] = l2; lat_cfg[3] = l3;
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_data = '0; job_tag = '0;
    res_ready = 1'b0; core_done = '0; core_hash = '0;
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0; m_data[i] = '0; m_tag[i] = '0; c_cnt[i] = 0; c_blk[i] = '0;
    end
    m_dptr = 0; m_optr = 0; m_sel = 0; m_pend = 1'b0; m_perr = 1'b0; m_en = '0; m_rstchk = 1'b0;
    dir_mode = 1'b1; job_taken = 1'b0; lat_rand = 1'b0;
    p_job = 0; p_ready = 100; inj_core = -1;
    set_lat(50, 50, 50, 50);

    @(negedge clk);
    cores_step();
    model_step();
    cycle(1'b0);

    // single job
    jq.push_back('{8'h11, {128{8'ha5}}});
    wait_idle(300);

    // fill: fifth job waits for the first freed core
    cycle(1'b1);
    set_lat(30, 30, 30, 30);
    for (int t = 1; t <= 5; t++) jq.push_back('{TAGW'(t), rand_block()});
    wait_idle(600);

    // out-of-order completion
    cycle(1'b1);
    set_lat(80, 20, 60, 40);
    for (int t = 1; t <= 4; t++) jq.push_back('{TAGW'(8'h20 + t), rand_block()});
    wait_idle(400);

    // backpressure with every core holding a result
    cycle(1'b1);
    set_lat(10, 12, 14, 16);
    p_ready = 0;
    for (int t = 1; t <= 4; t++) jq.push_back('{TAGW'(8'h30 + t), rand_block()});
    repeat (200) cycle(1'b0);
    p_ready = 100;
    wait_idle(100);

    // spurious done on an idle core
    inj_core = 2;
    repeat (10) cycle(1'b0);
    jq.push_back('{8'h44, rand_block()});
    wait_idle(200);

    // reset with three jobs in flight
    cycle(1'b1);
    set_lat(100, 100, 100, 100);
    for (int t = 1; t <= 3; t++) jq.push_back('{TAGW'(8'h50 + t), rand_block()});
    repeat (8) cycle(1'b0);
    cycle(1'b1);
    set_lat(15, 15, 15, 15);
    jq.push_back('{8'h66, rand_block()});
    wait_idle(300);

    // random traffic
    cycle(1'b1);
    dir_mode = 1'b0; lat_rand = 1'b1; p_job = 60; p_ready = 70;
    repeat (3000) cycle(1'b0);
    dir_mode = 1'b1; p_ready = 100;
    wait_idle(2000);
    cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
